sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the emulated SRAM.
- Each port issues a single read or write request. The block grants one port and drives the SRAM active-low strobes, address and write data.
- It holds the strobes stable for a fixed access window, captures read data, then acknowledges the port.
- It inserts a mandatory strobe-idle recovery cycle between accesses so the SRAM's internal access counter restarts cleanly.

Parameters:
- WIDTH, 16, data width (matches SRAM).
- RAM_ADDR_BITS, 17, address width (matches SRAM).
- ACCESS_CYCLES, 7, number of clocks the strobes stay asserted per access; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 op: 1 = write, 0 = read; stable while req0 is high.
- addr0  in  RAM_ADDR_BITS  port 0 address; stable while req0 is high.
- wdata0  in  WIDTH  port 0 write data; stable while req0 is high.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  WIDTH  port 0 read data; valid with ack0, held until the next port 0 read completes.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- sram_ce_n  out  1  SRAM chip enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_addr  out  RAM_ADDR_BITS  SRAM address.
- sram_wdata  out  WIDTH  SRAM write data.
- sram_rdata  in  WIDTH  SRAM read data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values:
  - sram_ce_n, sram_oe_n, sram_we_n = 1.
  - sram_addr, sram_wdata, rdata0, rdata1 = 0.
  - ack0, ack1, busy = 0.
  - State = IDLE; last-grant pointer = 1, so port 0 wins the first contention.
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE:
  - If any req is high at the edge, grant a port.
  - If exactly one port requests, grant it.
  - If both request, grant the port not equal to the last-grant pointer.
  - On grant: update the pointer, latch that port's addr/wdata/we into the sram_* outputs, load the cycle counter with ACCESS_CYCLES-1, and go to ACCESS.
  - Strobes at the grant edge:
    - Read: ce_n=0, oe_n=0, we_n=1.
    - Write: ce_n=0, oe_n=1, we_n=0.
- ACCESS:
  - Strobes, address and data are held constant; the counter decrements each edge.
  - At the edge where the counter is 0:
    - All strobes go to 1.
    - For a read, sram_rdata is latched into the granted port's rdata.
    - The granted port's ack is set to 1.
    - Go to RECOVER.
- Strobe-low duration is exactly ACCESS_CYCLES clocks.
- RECOVER:
  - Lasts one cycle with ack high; strobes stay 1.
  - At the next edge, ack clears and the FSM returns to IDLE.
- The requester samples ack and drops req at the same edge, so IDLE never re-grants a finished request.
- Latency:
  - Req high before edge E; grant at E.
  - Ack is high during the cycle after E+ACCESS_CYCLES.
  - Minimum issue spacing between grants is ACCESS_CYCLES+2 clocks.
- Requests arriving during ACCESS or RECOVER wait; they are neither dropped nor reordered.
- Input changes on the granted port during ACCESS are ignored; the latched values are used.
- A write never modifies rdata0 or rdata1.
- Reset mid-ACCESS: on the reset edge, strobes return to 1, the transaction is abandoned, no ack is issued, and the pointer is restored to 1.
- Never assert both oe_n=0 and we_n=0. Never drive ce_n=0 in IDLE or RECOVER.

Test Plan:
- Port 0 write:
  - Stimulus: req0=1, we0=1, addr0=0x00010, wdata0=0xBEEF.
  - Response: ce_n=0, we_n=0, oe_n=1 for exactly 7 clocks; sram_addr=0x00010, sram_wdata=0xBEEF; ack0 pulses once, 8 clocks after grant; busy drops after RECOVER.
- Port 0 read after that write:
  - Stimulus: req0=1, we0=0, addr0=0x00010, with the SRAM model attached.
  - Response: oe_n=0, we_n=1 for 7 clocks; rdata0=0xBEEF in the ack0 cycle, and still 0xBEEF afterwards.
- Simultaneous requests after reset:
  - Stimulus: req0 and req1 both asserted and held (port 1 writes 0x1234 to 0x1FFFF).
  - Response: port 0 is granted first; port 1 is granted in the IDLE cycle following port 0's RECOVER; grants alternate 0,1,0,1 over four back-to-back transactions.
- Request during busy:
  - Stimulus: req1 rises mid-ACCESS of port 0.
  - Response: port 1 is not granted until after RECOVER; rdata0 is unaffected; no ack1 before port 1's own window.
- Reset mid-access:
  - Stimulus: assert reset at the 3rd ACCESS clock of a port 1 write.
  - Response: all strobes 1 and busy 0 the next cycle; no ack1; with req0 and req1 both high after reset, port 0 is granted first.
- Protocol assertions, run across all scenarios:
  - Never oe_n=0 and we_n=0 together.
  - ce_n=0 only in ACCESS.
  - Strobe-low run length is always 7.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for the emulated SRAM.
// One access at a time: grant, fixed-length strobe window, ack, one idle recovery cycle.
module sram_access_arbiter #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned RAM_ADDR_BITS = 17,
    parameter int unsigned ACCESS_CYCLES = 7
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0,
    input  logic                     we0,
    input  logic [RAM_ADDR_BITS-1:0] addr0,
    input  logic [WIDTH-1:0]         wdata0,
    output logic                     ack0,
    output logic [WIDTH-1:0]         rdata0,

    input  logic                     req1,
    input  logic                     we1,
    input  logic [RAM_ADDR_BITS-1:0] addr1,
    input  logic [WIDTH-1:0]         wdata1,
    output logic                     ack1,
    output logic [WIDTH-1:0]         rdata1,

    output logic                     sram_ce_n,
    output logic                     sram_oe_n,
    output logic                     sram_we_n,
    output logic [RAM_ADDR_BITS-1:0] sram_addr,
    output logic [WIDTH-1:0]         sram_wdata,
    input  logic [WIDTH-1:0]         sram_rdata,

    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RECOVER
    } state_e;

    // Counter runs ACCESS_CYCLES-1 .. 0, so strobes stay low for exactly ACCESS_CYCLES clocks.
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     last_q, last_d;
    logic                     gnt_q, gnt_d;
    logic                     op_we_q, op_we_d;
    logic                     ce_n_q, ce_n_d;
    logic                     oe_n_q, oe_n_d;
    logic                     we_n_q, we_n_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]         wdata_q, wdata_d;
    logic [WIDTH-1:0]         rdata0_q, rdata0_d;
    logic [WIDTH-1:0]         rdata1_q, rdata1_d;
    logic                     ack0_q, ack0_d;
    logic                     ack1_q, ack1_d;
    logic                     busy_q, busy_d;

    logic                     any_req;
    logic                     pick;
    logic                     sel_we;
    logic [RAM_ADDR_BITS-1:0] sel_addr;
    logic [WIDTH-1:0]         sel_wdata;

    // Under contention the port that did not win last time goes next.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            pick = ~last_q;
        end else begin
            pick = req1 & ~req0;
        end
        sel_we    = pick ? we1    : we0;
        sel_addr  = pick ? addr1  : addr0;
        sel_wdata = pick ? wdata1 : wdata0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        op_we_d  = op_we_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0_d   = ack0_q;
        ack1_d   = ack1_q;
        busy_d   = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_LOAD;
                    last_d  = pick;
                    gnt_d   = pick;
                    op_we_d = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    ce_n_d  = 1'b0;
                    oe_n_d  = sel_we;
                    we_n_d  = ~sel_we;
                    busy_d  = 1'b1;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RECOVER;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (gnt_q) begin
                        ack1_d = 1'b1;
                    end else begin
                        ack0_d = 1'b1;
                    end
                    if (!op_we_q) begin
                        if (gnt_q) begin
                            rdata1_d = sram_rdata;
                        end else begin
                            rdata0_d = sram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RECOVER: begin
                state_d = ST_IDLE;
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            op_we_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            op_we_q  <= op_we_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
        end
    end

    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: SRAM responder, cycle-timed transaction model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_sram_access_arbiter;

    localparam int unsigned W  = 16;
    localparam int unsigned A  = 17;
    localparam int unsigned AC = 7;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [A-1:0] addr0 = '0, addr1 = '0;
    logic [W-1:0] wdata0 = '0, wdata1 = '0;
    logic         ack0, ack1, sram_ce_n, sram_oe_n, sram_we_n, busy;
    logic [W-1:0] rdata0, rdata1, sram_wdata, sram_rdata;
    logic [A-1:0] sram_addr;

    always #5 clk = ~clk;

    sram_access_arbiter #(
        .WIDTH         (W),
        .RAM_ADDR_BITS (A),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .ack0       (ack0),
        .rdata0     (rdata0),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .ack1       (ack1),
        .rdata1     (rdata1),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .busy       (busy)
    );

    // Emulated SRAM: written while write strobes are low, read data driven while read strobes are low.
    logic [W-1:0] sram_mem [0:(1<<A)-1];
    initial for (int i = 0; i < (1 << A); i++) sram_mem[i] = '0;
    always @(posedge clk) if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_wdata;
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : '0;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Transaction model: grant at cycle g, completion at g+AC, back to idle at g+AC+1.
    bit           m_valid = 1'b0, m_active = 1'b0, m_last = 1'b1, m_port, m_we;
    logic [A-1:0] m_addr;
    logic [W-1:0] m_wdata;
    int           m_cyc = 0, m_gedge = 0;
    logic [W-1:0] m_mem [int];
    logic [2:0]   e_strb;
    logic [A-1:0] e_addr;
    logic [W-1:0] e_wdata, e_rd0, e_rd1;
    logic         e_ack0, e_ack1, e_busy;

    int ack_q[$];
    int ack_cyc[$];
    int grant_cyc[$];

    initial begin : compare
        bit           s_rst, s_r0, s_r1, s_w0, s_w1, prev_ce_n;
        logic [A-1:0] s_a0, s_a1;
        logic [W-1:0] s_d0, s_d1, rv;
        int           k, run;
        prev_ce_n = 1'b1;
        run = 0;
        forever begin
            @(posedge clk);
            s_rst = reset; s_r0 = req0; s_r1 = req1; s_w0 = we0; s_w1 = we1;
            s_a0 = addr0; s_a1 = addr1; s_d0 = wdata0; s_d1 = wdata1;
            #1;
            m_cyc++;
            if (s_rst) begin
                m_valid = 1'b1; m_active = 1'b0; m_last = 1'b1;
                e_strb = 3'b111; e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
                e_ack0 = 1'b0; e_ack1 = 1'b0; e_busy = 1'b0;
            end else if (m_valid) begin
                if (m_active) begin
                    k = m_cyc - m_gedge;
                    if (k == AC) begin
                        e_strb = 3'b111;
                        if (m_port) e_ack1 = 1'b1; else e_ack0 = 1'b1;
                        if (m_we) m_mem[int'(m_addr)] = m_wdata;
                        else begin
                            rv = m_mem.exists(int'(m_addr)) ? m_mem[int'(m_addr)] : '0;
                            if (m_port) e_rd1 = rv; else e_rd0 = rv;
                        end
                    end else if (k == AC + 1) begin
                        e_ack0 = 1'b0; e_ack1 = 1'b0; e_busy = 1'b0; m_active = 1'b0;
                    end
                end else if (s_r0 || s_r1) begin
                    m_port  = (s_r0 && s_r1) ? !m_last : s_r1;
                    m_last  = m_port;
                    m_we    = m_port ? s_w1 : s_w0;
                    m_addr  = m_port ? s_a1 : s_a0;
                    m_wdata = m_port ? s_d1 : s_d0;
                    e_addr  = m_addr;
                    e_wdata = m_wdata;
                    e_strb  = m_we ? 3'b010 : 3'b001;  // {ce_n,oe_n,we_n}
                    e_busy  = 1'b1;
                    m_gedge = m_cyc;
                    m_active = 1'b1;
                end
            end
            if (m_valid) begin
                check("strobes", {sram_ce_n, sram_oe_n, sram_we_n}, e_strb);
                check("sram_addr", sram_addr, e_addr);
                check("sram_wdata", sram_wdata, e_wdata);
                check("acks", {ack1, ack0}, {e_ack1, e_ack0});
                check("rdata0", rdata0, e_rd0);
                check("rdata1", rdata1, e_rd1);
                check("busy", busy, e_busy);
                check("oe_we_both_low", !sram_oe_n && !sram_we_n, 1'b0);
                check("ce_outside_access", !sram_ce_n && !(busy && !ack0 && !ack1), 1'b0);
                if (!sram_ce_n) run++;
                else if (run != 0) begin
                    if (!s_rst) check("strobe_run_len", run, AC);
                    run = 0;
                end
                if (prev_ce_n && !sram_ce_n) grant_cyc.push_back(m_cyc);
                if (ack0) begin ack_q.push_back(0); ack_cyc.push_back(m_cyc); end
                if (ack1) begin ack_q.push_back(1); ack_cyc.push_back(m_cyc); end
                prev_ce_n = sram_ce_n;
            end
        end
    end

    task automatic do_req(input int p, input bit we, input logic [A-1:0] a,
                          input logic [W-1:0] d, output logic [W-1:0] rd);
        bit got = 1'b0;
        rd = '0;
        @(negedge clk);
        if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk); #1;
            if ((p == 0) ? ack0 : ack1) begin
                got = 1'b1;
                rd = (p == 0) ? rdata0 : rdata1;
            end
        end
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        if (!got) check($sformatf("port%0d_ack_wait", p), 32'd0, 32'd1);
    endtask

    task automatic clear_logs();
        ack_q.delete(); ack_cyc.delete(); grant_cyc.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [W-1:0] rd_a, rd_b;
        bit           got;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Port 0 write; ack seen AC edges after the grant edge (the 8th cycle counting the grant cycle).
        clear_logs();
        do_req(0, 1'b1, 17'h00010, 16'hBEEF, rd_a);
        check("wr_ack_count", ack_q.size(), 1);
        check("wr_ack_port", ack_q[0], 0);
        check("wr_ack_delay", ack_cyc[0] - grant_cyc[0], AC);
        check("wr_sram_content", sram_mem[17'h00010], 16'hBEEF);
        check("wr_rdata0_untouched", rdata0, 16'h0000);

        // Read back the same location.
        do_req(0, 1'b0, 17'h00010, 16'h0000, rd_a);
        check("rd_rdata0_at_ack", rd_a, 16'hBEEF);
        repeat (3) @(posedge clk);
        #1 check("rd_rdata0_held", rdata0, 16'hBEEF);

        // Simultaneous requests after reset: alternation 0,1,0,1 with AC+2 grant spacing.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        clear_logs();
        fork
            begin
                do_req(0, 1'b1, 17'h00020, 16'h5555, rd_a);
                do_req(0, 1'b1, 17'h00021, 16'h6666, rd_a);
            end
            begin
                do_req(1, 1'b1, 17'h1FFFF, 16'h1234, rd_b);
                do_req(1, 1'b1, 17'h1FFFE, 16'h4321, rd_b);
            end
        join
        check("alt_ack_count", ack_q.size(), 4);
        if (ack_q.size() == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("alt_order_%0d", i), ack_q[i], i % 2);
            for (int i = 1; i < 4; i++)
                check($sformatf("alt_gap_%0d", i), grant_cyc[i] - grant_cyc[i-1], AC + 2);
        end
        check("alt_sram_1ffff", sram_mem[17'h1FFFF], 16'h1234);

        // Port 1 request arrives mid-access of a port 0 read.
        repeat (3) @(posedge clk);
        clear_logs();
        fork
            do_req(0, 1'b0, 17'h00010, 16'h0000, rd_a);
            begin
                repeat (4) @(negedge clk);
                do_req(1, 1'b0, 17'h1FFFF, 16'h0000, rd_b);
            end
        join
        check("busy_ack_count", ack_q.size(), 2);
        check("busy_first_port", ack_q[0], 0);
        check("busy_second_port", ack_q[1], 1);
        check("busy_grant_gap", grant_cyc[1] - grant_cyc[0], AC + 2);
        check("busy_rd0", rd_a, 16'hBEEF);
        check("busy_rd1", rd_b, 16'h1234);
        check("busy_rdata0_kept", rdata0, 16'hBEEF);

        // Reset sampled at the 3rd ACCESS edge of a port 1 write.
        repeat (3) @(posedge clk);
        clear_logs();
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 17'h00300; wdata1 = 16'hA5A5;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (!sram_ce_n) got = 1'b1;
        end
        check("rst_grant_seen", got, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 17'h00010; wdata0 = 16'h0000;
        @(posedge clk);
        #1;
        check("rst_strobes_idle", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_busy_low", busy, 1'b0);
        check("rst_no_ack1", ack1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        fork
            do_req(0, 1'b0, 17'h00010, 16'h0000, rd_a);
            do_req(1, 1'b1, 17'h00300, 16'hA5A5, rd_b);
        join
        check("rst_ack_count", ack_q.size(), 2);
        check("rst_first_port", ack_q[0], 0);
        check("rst_second_port", ack_q[1], 1);
        check("rst_rd0", rd_a, 16'hBEEF);

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
